// File: rtl/calc_pkg.sv
// Shared calculator types plus the step/sequencer definitions used by the macro player.
package calc_pkg;

  localparam int unsigned NumDigits  = 4;
  localparam int unsigned NumButtons = 15;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    logic                  sign;
    bcd_t [NumDigits-1:0]  significand;
  } num_t;

  typedef enum logic [4:0] {
    B_NONE = 5'd0,
    NUM_0, NUM_1, NUM_2, NUM_3, NUM_4, NUM_5, NUM_6, NUM_7, NUM_8, NUM_9,
    OP_ADD, OP_SUB, OP_MUL, OP_EQ, OP_CLR
  } active_button_t;

  typedef logic [NumButtons-1:0] buttons_t;

  typedef struct packed {
    active_button_t button;
    bcd_t           expected;
  } seq_step_t;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_IDLE, S_RELEASE, S_PRESS, S_SETTLE, S_WAIT, S_CHECK, S_DONE
  } seq_state_e;

  // One-hot board encoding; B_NONE drives no button at all.
  function automatic buttons_t button2buttons(active_button_t b);
    buttons_t r;
    r = '0;
    if (b != B_NONE) r = buttons_t'(1) << (5'(b) - 5'd1);
    return r;
  endfunction

endpackage

// File: rtl/seq_step_buffer.sv
// Append-only step store with a combinational read port; cleared as a whole.
module seq_step_buffer
  import calc_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  seq_step_t                  wr_step_i,
  input  logic [$clog2(Depth)-1:0]   rd_idx_i,
  output seq_step_t                  rd_step_c,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_c
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  seq_step_t       mem_q [Depth];
  logic [IdxW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_write;

  assign full_c    = (count_q == CntW'(Depth));
  assign do_write  = wr_en_i && !full_c && !clear_i;
  assign count_o   = count_q;
  assign rd_step_c = mem_q[rd_idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (do_write) begin
      wr_ptr_q <= wr_ptr_q + IdxW'(1);
      count_q  <= count_q + CntW'(1);
    end
  end

  // Payload storage needs no reset: entries past count are never read.
  always_ff @(posedge clk_i) begin
    if (do_write) mem_q[wr_ptr_q] <= wr_step_i;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Button-macro player: replays stored steps into the calculator core and checks
// the display's most-significant digit once the controller returns to idle.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned Depth         = 16,
  parameter int unsigned PressCycles   = 2,
  parameter int unsigned ReleaseCycles = 1,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_valid_i,
  input  active_button_t               load_button_i,
  input  bcd_t                         load_expected_i,
  output logic                         load_ready_o,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic                         controller_idle_i,
  input  num_t                         display_rdata_i,
  output buttons_t                     buttons_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [$clog2(Depth+1)-1:0]   error_count_o,
  output logic [$clog2(Depth)-1:0]     first_fail_o,
  output logic                         timeout_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned TmrW = $clog2(TimeoutCycles + PressCycles + ReleaseCycles + 3);

  seq_state_e      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d, ff_q, ff_d;
  logic [CntW-1:0] err_q, err_d, count;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            to_q, to_d, pass_q, pass_d;
  logic            busy_q, busy_d, done_q, done_d;
  buttons_t        buttons_q, buttons_d;
  seq_step_t       step;
  logic            full, idle_clear, wr_en, last_step, mismatch, tmr_expired;
  logic            unused_display;

  assign idle_clear   = clear_i && (state_q == S_IDLE);
  assign load_ready_o = (state_q == S_IDLE) && !full;
  assign wr_en        = load_valid_i && load_ready_o && !idle_clear;

  seq_step_buffer #(.Depth(Depth)) u_buffer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (idle_clear),
    .wr_en_i   (wr_en),
    .wr_step_i ('{button: load_button_i, expected: load_expected_i}),
    .rd_idx_i  (idx_q),
    .rd_step_c (step),
    .count_o   (count),
    .full_c    (full)
  );

  assign last_step      = (CntW'(idx_q) == count - CntW'(1));
  assign mismatch       = (step.expected != display_rdata_i.significand[NumDigits-1]);
  assign tmr_expired    = (tmr_q == TmrW'(TimeoutCycles - 1));
  assign unused_display = ^{display_rdata_i.sign, display_rdata_i.significand[NumDigits-2:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; the shared timer restarts on every state change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_i) state_d = (count == '0) ? S_DONE : S_PRE_IDLE;
      S_PRE_IDLE: if (controller_idle_i) state_d = S_RELEASE;
                  else if (tmr_expired)  state_d = S_DONE;
      S_RELEASE:  if (tmr_q == TmrW'(ReleaseCycles - 1)) state_d = S_PRESS;
      S_PRESS:    if (tmr_q == TmrW'(PressCycles - 1))   state_d = S_SETTLE;
      S_SETTLE:   if (tmr_q == TmrW'(1))                 state_d = S_WAIT;
      S_WAIT:     if (controller_idle_i) state_d = S_CHECK;
                  else if (tmr_expired)  state_d = S_DONE;
      S_CHECK:    state_d = last_step ? S_DONE : S_RELEASE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tmr_d  = (state_d != state_q) ? '0 : tmr_q + TmrW'(1);
    idx_d  = idx_q;
    err_d  = err_q;
    ff_d   = ff_q;
    to_d   = to_q;
    pass_d = pass_q;

    if (state_q == S_IDLE && start_i) begin
      idx_d  = '0;
      err_d  = '0;
      ff_d   = '0;
      to_d   = 1'b0;
      pass_d = 1'b0;
    end

    if ((state_q == S_PRE_IDLE || state_q == S_WAIT) && !controller_idle_i && tmr_expired)
      to_d = 1'b1;

    if (state_q == S_CHECK) begin
      if (mismatch) begin
        if (err_q != CntW'(Depth)) err_d = err_q + CntW'(1);
        if (err_q == '0)           ff_d  = idx_q;
      end
      if (!last_step) idx_d = idx_q + IdxW'(1);
    end

    if (state_d == S_DONE) pass_d = (err_d == '0) && !to_d;

    buttons_d = (state_d == S_PRESS) ? button2buttons(step.button) : button2buttons(B_NONE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmr_q     <= '0;
      idx_q     <= '0;
      err_q     <= '0;
      ff_q      <= '0;
      to_q      <= 1'b0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      buttons_q <= button2buttons(B_NONE);
    end else begin
      tmr_q     <= tmr_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      ff_q      <= ff_d;
      to_q      <= to_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      buttons_q <= buttons_d;
    end
  end

  assign buttons_o     = buttons_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign error_count_o = err_q;
  assign first_fail_o  = ff_q;
  assign timeout_o     = to_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: a stub controller/display answers each press and
// results are checked against mismatch counts computed from the step tables.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int unsigned Depth   = 8;
  localparam int unsigned Press   = 2;
  localparam int unsigned Release = 1;
  localparam int unsigned Timeout = 16;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           load_valid_i;
  active_button_t load_button_i;
  bcd_t           load_expected_i;
  logic           load_ready_o;
  logic           clear_i;
  logic           start_i;
  logic           controller_idle_i;
  num_t           display_rdata_i;
  buttons_t       buttons_o;
  logic           busy_o, done_o, pass_o, timeout_o;
  logic [3:0]     error_count_o;
  logic [2:0]     first_fail_o;

  calc_sequencer #(
    .Depth(Depth), .PressCycles(Press), .ReleaseCycles(Release), .TimeoutCycles(Timeout)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .load_valid_i(load_valid_i), .load_button_i(load_button_i),
    .load_expected_i(load_expected_i), .load_ready_o(load_ready_o), .clear_i(clear_i),
    .start_i(start_i), .controller_idle_i(controller_idle_i), .display_rdata_i(display_rdata_i),
    .buttons_o(buttons_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .error_count_o(error_count_o), .first_fail_o(first_fail_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Step tables written by the stimulus: button, loaded expectation, digit the "calculator" shows.
  active_button_t btn_a [Depth+2];
  int             exp_a [Depth+2];
  int             act_a [Depth+2];
  bit             stuck;
  int             run_base;

  // Stub state, written only by the stub process.
  buttons_t   log_q[$];
  int         press_count = 0;
  int         width_bad   = 0;
  int         done_cnt    = 0;
  int         busy_cnt    = 0;
  int         cur_width   = 0;
  buttons_t   prev_btn    = '0;
  logic [3:0] disp_msd    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stub controller: busy for a random while after each press, display MSD from act_a.
  always @(negedge clk) begin
    int k;
    if (rst_i) begin
      prev_btn = '0;
      busy_cnt = 0;
    end else begin
      if (buttons_o != '0) begin
        if (prev_btn == '0) begin
          log_q.push_back(buttons_o);
          k = press_count - run_base;
          disp_msd = (k >= 0 && k < Depth + 2) ? 4'(act_a[k]) : 4'd0;
          press_count++;
          cur_width = 0;
        end
        cur_width++;
        busy_cnt = int'($urandom_range(1, 6));
      end else if (prev_btn != '0) begin
        if (cur_width != Press) width_bad++;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      prev_btn = buttons_o;
      if (done_o) done_cnt++;
    end
    controller_idle_i    = !stuck && (busy_cnt == 0);
    display_rdata_i.sign = 1'($urandom_range(0, 1));
    for (int i = 0; i < NumDigits - 1; i++)
      display_rdata_i.significand[i] = 4'($urandom_range(0, 9));
    display_rdata_i.significand[NumDigits-1] = disp_msd;
  end

  function automatic buttons_t onehot(input active_button_t b);
    buttons_t r;
    r = '0;
    r[int'(b) - 1] = 1'b1;
    return r;
  endfunction

  task automatic do_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      load_valid_i    = 1'b1;
      load_button_i   = btn_a[i];
      load_expected_i = 4'(exp_a[i]);
      @(negedge clk);
    end
    load_valid_i = 1'b0;
  endtask

  task automatic run(input int n, input string tag, input bit expect_to);
    int e, ff, base_w, base_d, k;
    e = 0;
    ff = 0;
    if (!expect_to)
      for (int i = 0; i < n; i++)
        if (exp_a[i] != act_a[i]) begin
          if (e == 0) ff = i;
          e++;
        end
    run_base = press_count;
    base_w   = width_bad;
    base_d   = done_cnt;
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (done_cnt == base_d && k < 3000) begin
      @(negedge clk);
      k++;
      start_i = 1'b0;
      if (k == 20 && busy_o && !done_o) start_i = 1'b1;
    end
    start_i = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_cnt != base_d), 1);
    repeat (4) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - base_d, 1);
    chk({tag, "_err"}, error_count_o, e);
    chk({tag, "_first_fail"}, first_fail_o, ff);
    chk({tag, "_pass"}, pass_o, (e == 0 && !expect_to) ? 1 : 0);
    chk({tag, "_timeout"}, timeout_o, expect_to ? 1 : 0);
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_buttons_off"}, buttons_o, 0);
    chk({tag, "_presses"}, press_count - run_base, expect_to ? 0 : n);
    chk({tag, "_press_width"}, width_bad - base_w, 0);
    if (!expect_to)
      for (int i = 0; i < n; i++)
        if (run_base + i < log_q.size())
          chk({tag, "_button"}, log_q[run_base + i], onehot(btn_a[i]));
  endtask

  task automatic empty_start(input string tag);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_pass"}, pass_o, 1);
    chk({tag, "_err"}, error_count_o, 0);
    @(negedge clk);
    chk({tag, "_done_drop"}, done_o, 0);
  endtask

  task automatic set_base_table();
    btn_a[0] = NUM_1;
    btn_a[1] = OP_ADD;
    for (int i = 2; i < 7; i++) btn_a[i] = OP_EQ;
    for (int i = 0; i < 7; i++) act_a[i] = (i < 3) ? 1 : i - 1;
    for (int i = 0; i < 7; i++) exp_a[i] = act_a[i];
  endtask

  initial begin
    int n, pc;
    rst_i = 1'b1;
    load_valid_i = 1'b0;
    load_button_i = B_NONE;
    load_expected_i = '0;
    clear_i = 1'b0;
    start_i = 1'b0;
    stuck = 1'b0;
    run_base = 0;
    for (int i = 0; i < Depth + 2; i++) begin
      btn_a[i] = NUM_0;
      exp_a[i] = 0;
      act_a[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_buttons", buttons_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_err", error_count_o, 0);
    chk("rst_first_fail", first_fail_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_load_ready", load_ready_o, 1);
    rst_i = 1'b0;
    @(negedge clk);

    set_base_table();
    load(7);
    run(7, "all_match", 1'b0);

    do_clear();
    exp_a[3] = 7;
    load(7);
    run(7, "one_miss", 1'b0);

    do_clear();
    exp_a[3] = act_a[3];
    exp_a[2] = 8;
    exp_a[5] = 0;
    load(7);
    run(7, "two_miss", 1'b0);

    do_clear();
    for (int i = 0; i < Depth; i++) begin
      btn_a[i] = active_button_t'(5'(i + 1));
      act_a[i] = i;
      exp_a[i] = (i + 5) % 10;
    end
    load(Depth);
    run(Depth, "all_miss", 1'b0);

    for (int r = 0; r < 6; r++) begin
      do_clear();
      n = int'($urandom_range(1, Depth));
      for (int i = 0; i < n; i++) begin
        btn_a[i] = active_button_t'(5'($urandom_range(1, 15)));
        act_a[i] = int'($urandom_range(0, 9));
        exp_a[i] = ($urandom_range(0, 3) == 0) ? (act_a[i] + 1 + int'($urandom_range(0, 8))) % 10
                                                : act_a[i];
      end
      load(n);
      run(n, "random", 1'b0);
    end

    stuck = 1'b1;
    do_clear();
    load(3);
    run(3, "timeout", 1'b1);
    stuck = 1'b0;

    do_clear();
    for (int i = 0; i < Depth + 2; i++) begin
      btn_a[i] = active_button_t'(5'($urandom_range(1, 15)));
      act_a[i] = int'($urandom_range(0, 9));
      exp_a[i] = act_a[i];
    end
    for (int i = 0; i < Depth + 2; i++) begin
      chk("fill_ready", load_ready_o, (i < Depth) ? 1 : 0);
      load_valid_i    = 1'b1;
      load_button_i   = btn_a[i];
      load_expected_i = 4'(exp_a[i]);
      @(negedge clk);
    end
    load_valid_i = 1'b0;
    chk("full_ready", load_ready_o, 0);
    run(Depth, "full", 1'b0);

    do_clear();
    empty_start("empty");

    clear_i = 1'b1;
    load_valid_i = 1'b1;
    load_button_i = NUM_3;
    load_expected_i = 4'd3;
    @(negedge clk);
    clear_i = 1'b0;
    load_valid_i = 1'b0;
    pc = press_count;
    empty_start("clear_wins");
    repeat (3) @(negedge clk);
    chk("clear_wins_no_press", press_count - pc, 0);

    load(2);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (buttons_o == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_press_seen", 32'(buttons_o != '0), 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid_buttons", buttons_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_err", error_count_o, 0);
    @(negedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", load_ready_o, 1);
    empty_start("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Synthesizable, parametrised button-macro player and self-checker for the calculator core.
- Stores up to Depth steps (button plus expected display MSD) and replays them into sanitize_buttons with release/press/settle timing.
- Waits for the controller to go idle after each step, then compares the display's most-significant digit and reports pass/fail.
- Sits beside the board button inputs; a mux selecting between physical buttons and buttons_o is outside this block.

Parameters:
- Depth, 16, max steps stored (power of 2, ≥2).
- PressCycles, 2, cycles a button is held.
- ReleaseCycles, 1, cycles B_NONE is driven before each press.
- TimeoutCycles, 256, max cycles waiting for controller idle per step.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous active-high
- load_valid_i  in  1  append step
- load_button_i  in  active_button_t  step button
- load_expected_i  in  bcd_t  expected display MSD after step
- load_ready_o  out  1  buffer not full and sequencer idle
- clear_i  in  1  empty step buffer (ignored while busy)
- start_i  in  1  begin replay
- controller_idle_i  in  1  controller FSM in its idle state
- display_rdata_i  in  num_t  display register value
- buttons_o  out  buttons_t  one-hot-encoded button drive
- busy_o  out  1  replay in progress
- done_o  out  1  one-cycle pulse at end of replay
- pass_o  out  1  last replay had zero mismatches and no timeout
- error_count_o  out  $clog2(Depth+1)  mismatches in last replay
- first_fail_o  out  $clog2(Depth)  index of first mismatching step
- timeout_o  out  1  last replay aborted on timeout

Behaviour:
- Reset (async):
  - Buffer empty; FSM in S_IDLE.
  - buttons_o=button2buttons(B_NONE); busy_o=0, done_o=0, pass_o=0.
  - error_count_o=0, first_fail_o=0, timeout_o=0, load_ready_o=1.
- Load:
  - Write occurs when load_valid_i && load_ready_o.
  - Count saturates at Depth; load_ready_o=0 when full or busy.
  - clear_i in S_IDLE zeroes the count; clear and load in the same cycle means clear wins.
- start_i in S_IDLE:
  - Count==0: done_o pulses next cycle with pass_o=1, error_count_o=0; no buttons are driven.
  - Otherwise: clear error_count_o, timeout_o and first_fail_o; step index=0; enter S_PRE_IDLE.
- start_i while busy: ignored.
- FSM states:
  - S_IDLE.
  - S_PRE_IDLE: wait controller_idle_i=1; timeout counter runs.
  - S_RELEASE: drive B_NONE for ReleaseCycles.
  - S_PRESS: drive step button for PressCycles.
  - S_SETTLE: drive B_NONE for 2 cycles so the controller observes new_input.
  - S_WAIT: wait controller_idle_i=1; timeout counter runs.
  - S_CHECK: 1 cycle; compare display_rdata_i.significand[NumDigits-1] with expected.
  - S_DONE: 1 cycle; done_o=1.
- S_CHECK outcomes:
  - Mismatch: error_count_o+1, saturating at Depth. first_fail_o is set on the first mismatch only.
  - index==count-1: go to S_DONE; else index+1, go to S_RELEASE.
- Timeout: counter reaches TimeoutCycles in S_PRE_IDLE or S_WAIT → timeout_o=1, go to S_DONE, buttons_o=B_NONE.
- pass_o is updated in S_DONE = (error_count_o==0 && !timeout_o) and held until the next start.
- busy_o=1 in every state except S_IDLE; buttons_o is registered.
- Step latency: ReleaseCycles+PressCycles+2+idle wait+1 cycles.
- Reset mid-replay: immediate return to reset values; buffer contents are lost.

Decomposition:
- calc_pkg additions:
  - function button2buttons(active_button_t) → buttons_t, moved out of the DV package so RTL can use it.
  - seq_step_t struct {active_button_t button; bcd_t expected;}.
  - seq_state_e enum.
- Sub-module seq_step_buffer:
  - Depth-entry seq_step_t storage, write pointer and count, combinational read port by index.
  - Same clock and reset.

Test Plan:
- Load {NUM_1, OP_ADD, OP_EQ×5} with expected {1,1,1,2,3,4,5}, start → done_o pulse, pass_o=1, error_count_o=0.
- Same load but step 3 expects 7 → error_count_o=1, first_fail_o=3, pass_o=0.
- Two mismatches at steps 2 and 5 → error_count_o=2, first_fail_o=2.
- Stub controller_idle_i held 0 with TimeoutCycles=16 → timeout_o=1, pass_o=0, buttons_o=B_NONE, done_o exactly once.
- Load Depth+2 steps → load_ready_o=0 after Depth writes, count=Depth; start with empty buffer → immediate done_o, pass_o=1.
- Assert rst_i during S_PRESS → buttons_o=B_NONE and busy_o=0 asynchronously; a subsequent start with count 0 passes trivially.
